// File: rtl/sdb_delta_sequencer.sv
// Step sequencer that plays a table of {dRe, dIm} rotation deltas into the
// SineSDB64 deltas stream, holding each entry for a programmable dwell.
module sdb_delta_sequencer #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int DWELL_WIDTH = 32
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [63:0]            cfg_data,
    input  logic [AW:0]            n_steps,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic                   loop_mode,
    input  logic                   start,
    input  logic                   stop,
    output logic [63:0]            M_AXIS_DELTAS_tdata,
    output logic                   M_AXIS_DELTAS_tvalid,
    input  logic                   M_AXIS_DELTAS_tready,
    output logic [AW-1:0]          step_index,
    output logic                   step_strobe,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DWELL,
        FINISH
    } state_t;

    state_t                 state;
    logic [63:0]            tbl [DEPTH];
    logic [AW-1:0]          idx;
    logic [AW-1:0]          idx_nx;
    logic [AW:0]            nsteps_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [DWELL_WIDTH-1:0] cnt;
    logic                   loop_q;
    logic                   start_ok;
    logic                   more;

    assign idx_nx   = idx + 1'b1;
    assign more     = ({1'b0, idx} + 1'b1) < nsteps_q;
    assign start_ok = (n_steps != '0) && (n_steps <= (AW+1)'(DEPTH));

    // Table is deliberately outside reset so a configured pattern survives it.
    always_ff @(posedge aclk) begin
        if (cfg_we) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state                <= IDLE;
            M_AXIS_DELTAS_tdata  <= '0;
            M_AXIS_DELTAS_tvalid <= 1'b0;
            step_index           <= '0;
            step_strobe          <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            idx                  <= '0;
            nsteps_q             <= '0;
            dwell_q              <= '0;
            cnt                  <= '0;
            loop_q               <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                state                <= IDLE;
                M_AXIS_DELTAS_tvalid <= 1'b0;
                busy                 <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && start_ok) begin
                            nsteps_q <= n_steps;
                            dwell_q  <= (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
                            loop_q   <= loop_mode;
                            idx      <= '0;
                            busy     <= 1'b1;
                            M_AXIS_DELTAS_tdata  <= tbl[0];
                            M_AXIS_DELTAS_tvalid <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (M_AXIS_DELTAS_tready) begin
                            M_AXIS_DELTAS_tvalid <= 1'b0;
                            step_strobe <= 1'b1;
                            step_index  <= idx;
                            cnt         <= dwell_q;
                            state       <= DWELL;
                        end
                    end
                    DWELL: begin
                        if (cnt > DWELL_WIDTH'(1)) begin
                            cnt <= cnt - 1'b1;
                        end else if (more) begin
                            idx <= idx_nx;
                            M_AXIS_DELTAS_tdata  <= tbl[idx_nx];
                            M_AXIS_DELTAS_tvalid <= 1'b1;
                            state <= LOAD;
                        end else if (loop_q) begin
                            idx <= '0;
                            M_AXIS_DELTAS_tdata  <= tbl[0];
                            M_AXIS_DELTAS_tvalid <= 1'b1;
                            state <= LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdb_delta_sequencer.sv
// Self-checking bench for sdb_delta_sequencer: timeline model plus
// directed scenarios with hand-computed expectations.
module tb_sdb_delta_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [63:0] cfg_data;
    logic [4:0]  n_steps;
    logic [31:0] dwell;
    logic        loop_mode;
    logic        start;
    logic        stop;
    logic        tready;
    logic [63:0] tdata;
    logic        tvalid;
    logic [3:0]  sidx;
    logic        strobe;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [63:0] tv [16];

    sdb_delta_sequencer #(.DEPTH(16), .AW(4), .DWELL_WIDTH(32)) dut (
        .aclk                 (clk),
        .reset                (reset),
        .cfg_we               (cfg_we),
        .cfg_addr             (cfg_addr),
        .cfg_data             (cfg_data),
        .n_steps              (n_steps),
        .dwell                (dwell),
        .loop_mode            (loop_mode),
        .start                (start),
        .stop                 (stop),
        .M_AXIS_DELTAS_tdata  (tdata),
        .M_AXIS_DELTAS_tvalid (tvalid),
        .M_AXIS_DELTAS_tready (tready),
        .step_index           (sidx),
        .step_strobe          (strobe),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Timeline model: expected outputs for the current cycle, advanced at
    // each negedge from the inputs seen in that cycle.
    logic [63:0] mtbl [16];
    bit          mknown = 0;
    logic        e_valid, e_strobe, e_busy, e_done;
    logic [63:0] e_data;
    int          e_sidx;
    int          m_n, m_dw, m_pos, next_load;
    bit          m_lp;

    always @(negedge clk) begin
        logic n_strobe, n_done;
        if (mknown) begin
            chk("model_tvalid", tvalid, e_valid);
            chk("model_tdata", tdata, e_data);
            chk("model_strobe", strobe, e_strobe);
            chk("model_index", sidx, e_sidx[3:0]);
            chk("model_busy", busy, e_busy);
            chk("model_done", done, e_done);
        end
        n_strobe = 0;
        n_done   = 0;
        if (reset) begin
            mknown  = 1;
            e_valid = 0;
            e_data  = '0;
            e_sidx  = 0;
            e_busy  = 0;
            m_pos   = 0;
        end else if (stop) begin
            e_valid = 0;
            e_busy  = 0;
        end else if (!e_busy) begin
            if (start && n_steps >= 1 && n_steps <= 16) begin
                m_n     = int'(n_steps);
                m_dw    = (dwell == 0) ? 1 : int'(dwell);
                m_lp    = loop_mode;
                m_pos   = 0;
                e_valid = 1;
                e_data  = mtbl[0];
                e_busy  = 1;
            end
        end else if (e_done) begin
            e_busy = 0;
        end else if (e_valid) begin
            if (tready) begin
                e_valid   = 0;
                n_strobe  = 1;
                e_sidx    = m_pos;
                next_load = cyc + m_dw + 1;
            end
        end else if (cyc + 1 == next_load) begin
            if (m_pos + 1 < m_n) begin
                m_pos   = m_pos + 1;
                e_valid = 1;
                e_data  = mtbl[m_pos];
            end else if (m_lp) begin
                m_pos   = 0;
                e_valid = 1;
                e_data  = mtbl[0];
            end else begin
                n_done = 1;
            end
        end
        e_strobe = n_strobe;
        e_done   = n_done;
        if (cfg_we) mtbl[cfg_addr] = cfg_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1;
        tick();
        stop = 0;
    endtask

    // sel: 0 strobe, 1 tvalid, 2 done. Ends at the negedge of the hit cycle.
    task automatic wait_until(input int sel, input int budget,
                              input string nm);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel == 0 && strobe) || (sel == 1 && tvalid) ||
                (sel == 2 && done)) begin
                found = 1;
                break;
            end
            tick();
        end
        chk(nm, 64'(found), 64'd1);
    endtask

    task automatic setup(input int n, input int dw, input bit lp);
        n_steps   = 5'(n);
        dwell     = 32'(dw);
        loop_mode = lp;
    endtask

    initial begin
        int idxs[$];
        int cycs[$];
        int c0, c1, cd, t1, last;
        bit sawdone;

        reset = 1; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        n_steps = 0; dwell = 0; loop_mode = 0;
        start = 0; stop = 0; tready = 1;

        for (int i = 0; i < 16; i++) begin
            tv[i]    = {32'(i) * 32'h0101_0101 + 32'h1000_0000,
                        32'hA5A5_0000 | 32'(i)};
            cfg_we   = 1;
            cfg_addr = 4'(i);
            cfg_data = tv[i];
            tick();
        end
        cfg_we = 0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_tvalid", tvalid, 0);
        chk("reset_tdata", tdata, 0);
        tick();
        reset = 0;
        tick();

        // single step
        tv[0]    = 64'h7FE8_C6A9_04D3_0C2A;
        cfg_we   = 1;
        cfg_addr = 0;
        cfg_data = tv[0];
        tick();
        cfg_we = 0;
        setup(1, 5, 0);
        pulse_start();
        @(negedge clk);
        chk("single_tvalid", tvalid, 1);
        chk("single_tdata", tdata, 64'h7FE8_C6A9_04D3_0C2A);
        tick();
        @(negedge clk);
        chk("single_strobe", strobe, 1);
        chk("single_index", sidx, 0);
        repeat (5) tick();
        @(negedge clk);
        chk("single_done", done, 1);
        chk("single_busy_at_done", busy, 1);
        tick();
        @(negedge clk);
        chk("single_busy_low", busy, 0);
        chk("single_done_low", done, 0);
        tick();

        // loop wrap
        setup(3, 2, 1);
        pulse_start();
        sawdone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (strobe) begin
                idxs.push_back(int'(sidx));
                cycs.push_back(cyc);
            end
            if (done) sawdone = 1;
            tick();
        end
        chk("loop_strobes", 64'(idxs.size() >= 6), 1);
        for (int k = 0; k < 6; k++) begin
            if (k < idxs.size()) chk("loop_index", 64'(idxs[k]), 64'(k % 3));
        end
        for (int k = 1; k < 6; k++) begin
            if (k < cycs.size())
                chk("loop_period", 64'(cycs[k] - cycs[k-1]), 3);
        end
        chk("loop_no_done", 64'(sawdone), 0);
        pulse_stop();
        @(negedge clk);
        chk("loop_stop_busy", busy, 0);
        chk("loop_stop_tvalid", tvalid, 0);
        tick();

        // backpressure on the second load
        setup(3, 3, 0);
        pulse_start();
        wait_until(0, 10, "bp_first_strobe");
        tick();
        tready = 0;
        wait_until(1, 10, "bp_second_load");
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_hold_tvalid", tvalid, 1);
            chk("bp_hold_tdata", tdata, tv[1]);
            tick();
        end
        tready = 1;
        tick();
        @(negedge clk);
        chk("bp_strobe", strobe, 1);
        chk("bp_index", sidx, 1);
        repeat (2) tick();
        @(negedge clk);
        chk("bp_dwell_tvalid_low", tvalid, 0);
        tick();
        @(negedge clk);
        chk("bp_next_tvalid", tvalid, 1);
        chk("bp_next_tdata", tdata, tv[2]);
        tick();
        wait_until(2, 20, "bp_done");
        tick();
        tick();

        // stop during dwell of step 1
        setup(3, 4, 0);
        pulse_start();
        wait_until(0, 10, "stopd_strobe0");
        tick();
        wait_until(0, 10, "stopd_strobe1");
        chk("stopd_index", sidx, 1);
        tick();
        pulse_stop();
        @(negedge clk);
        chk("stopd_busy", busy, 0);
        chk("stopd_tvalid", tvalid, 0);
        chk("stopd_strobe", strobe, 0);
        sawdone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            @(negedge clk);
            if (done || tvalid) sawdone = 1;
        end
        chk("stopd_quiet", 64'(sawdone), 0);
        tick();

        // stop during a stalled load
        tready = 0;
        pulse_start();
        @(negedge clk);
        chk("stopl_tvalid_pre", tvalid, 1);
        tick();
        pulse_stop();
        tready = 1;
        @(negedge clk);
        chk("stopl_tvalid", tvalid, 0);
        chk("stopl_busy", busy, 0);
        tick();

        // start and stop together
        start = 1;
        stop  = 1;
        tick();
        start = 0;
        stop  = 0;
        @(negedge clk);
        chk("startstop_busy", busy, 0);
        chk("startstop_tvalid", tvalid, 0);
        tick();

        // bad step counts
        setup(0, 2, 0);
        pulse_start();
        @(negedge clk);
        chk("nsteps0_busy", busy, 0);
        tick();
        setup(17, 2, 0);
        pulse_start();
        @(negedge clk);
        chk("nsteps17_busy", busy, 0);
        chk("nsteps17_tvalid", tvalid, 0);
        tick();

        // dwell of zero acts as one
        setup(2, 0, 0);
        pulse_start();
        wait_until(0, 10, "dw0_strobe0");
        c0 = cyc;
        tick();
        wait_until(0, 10, "dw0_strobe1");
        c1 = cyc;
        chk("dw0_period", 64'(c1 - c0), 2);
        tick();
        wait_until(2, 10, "dw0_done");
        cd = cyc;
        chk("dw0_done_time", 64'(cd - c0), 3);
        tick();
        tick();

        // full depth, with a start while busy
        setup(16, 1, 0);
        pulse_start();
        @(negedge clk);
        t1 = cyc;
        repeat (3) tick();
        setup(1, 0, 0);
        start = 1;
        tick();
        start = 0;
        last = -1;
        sawdone = 0;
        cd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (strobe) last = int'(sidx);
            if (done) begin
                sawdone = 1;
                cd = cyc;
                break;
            end
            tick();
        end
        chk("full_done_seen", 64'(sawdone), 1);
        chk("full_last_index", 64'(last), 15);
        chk("full_done_time", 64'(cd - t1), 32);
        tick();
        tick();

        // reset mid-dwell
        setup(2, 5, 1);
        pulse_start();
        wait_until(0, 10, "rst_strobe0");
        tick();
        wait_until(0, 10, "rst_strobe1");
        tick();
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_index", sidx, 0);
        chk("rst_strobe", strobe, 0);
        chk("rst_done", done, 0);
        tick();

        // write to entry 0 in the cycle it is registered
        setup(2, 2, 1);
        cfg_we   = 1;
        cfg_addr = 0;
        cfg_data = 64'hDEAD_BEEF_0BAD_F00D;
        start    = 1;
        tick();
        cfg_we = 0;
        start  = 0;
        @(negedge clk);
        chk("hazard_old_value", tdata, 64'h7FE8_C6A9_04D3_0C2A);
        tick();
        wait_until(0, 10, "hazard_strobe0");
        tick();
        wait_until(0, 10, "hazard_strobe1");
        tick();
        tick();
        @(negedge clk);
        chk("hazard_reload_tvalid", tvalid, 1);
        chk("hazard_new_value", tdata, 64'hDEAD_BEEF_0BAD_F00D);
        tick();
        pulse_stop();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
